// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipeline.
package cpu_pkg;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/dff.sv
// Generic W-bit flop with write enable and asynchronous active-low reset.
module dff #(
  parameter int W = 1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d on enabled edges; clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= {W{1'b0}};
    end else if (wen) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/memwb_register.sv
// MEM/WB pipeline register. Always written every cycle; bubbles are
// formed upstream by forcing rf_write_d low, never by gating the enable.
module memwb_register
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          rf_write_d,
  input  logic [RW-1:0] write_reg_d,
  input  logic [DW-1:0] data_d,
  output logic          rf_write_q,
  output logic [RW-1:0] write_reg_q,
  output logic [DW-1:0] data_q
);

  dff #(.W(1)) u_rf_write (
    .clk(clk), .rst(rst), .wen(1'b1), .d(rf_write_d), .q(rf_write_q)
  );

  dff #(.W(RW)) u_write_reg (
    .clk(clk), .rst(rst), .wen(1'b1), .d(write_reg_d), .q(write_reg_q)
  );

  dff #(.W(DW)) u_data (
    .clk(clk), .rst(rst), .wen(1'b1), .d(data_d), .q(data_q)
  );

endmodule

// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores against a variable-latency data memory over
// a req/ack handshake, stalls upstream while an access is in flight, and
// owns the MEM/WB register. Optional build macro MEM_FWD_EN forwards
// MEM/WB write data into the store data path.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DW             = cpu_pkg::DW,
  parameter int RW             = cpu_pkg::RW,
  parameter int TIMEOUT_CYCLES = 64
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_rf_write,
  input  logic          ex_dm_write,
  input  logic          ex_memtoreg,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_read_reg2,
  input  logic [RW-1:0] ex_write_reg,
  output logic          dm_req,
  output logic          dm_we,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic          dm_ack,
  input  logic [DW-1:0] dm_rdata,
  output logic          mem_stall,
  output logic          mem_err,
  output logic          wb_rf_write,
  output logic [RW-1:0] wb_write_reg,
  output logic [DW-1:0] wb_data
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  mem_state_t     state_r;
  logic [15:0]    cnt_r;
  logic           mem_op_s;
  logic           timeout_s;
  logic [DW-1:0]  store_data_s;
  logic           wb_rf_write_d_s;
  logic [RW-1:0]  wb_write_reg_d_s;
  logic [DW-1:0]  wb_data_d_s;

  assign mem_op_s  = ex_dm_write | ex_memtoreg;
  assign timeout_s = TO_EN && (state_r == BUSY) && !dm_ack && (cnt_r == TO_LAST);

`ifdef MEM_FWD_EN
  // Forward the value about to be written back when the store reads it.
  always_comb begin
    store_data_s = ex_store_data;
    if (ex_dm_write && wb_rf_write && (wb_write_reg != RW'(REG_ZERO)) &&
        (ex_read_reg2 == wb_write_reg)) begin
      store_data_s = wb_data;
    end else begin
      store_data_s = ex_store_data;
    end
  end
`else
  logic unused_read_reg2_s;
  assign unused_read_reg2_s = ^ex_read_reg2;
  assign store_data_s = ex_store_data;
`endif

  // Stall decision and next MEM/WB contents; bubbles force rf_write low.
  always_comb begin
    mem_stall        = 1'b0;
    wb_rf_write_d_s  = 1'b0;
    wb_write_reg_d_s = ex_write_reg;
    wb_data_d_s      = ex_result;
    case (state_r)
      IDLE: begin
        if (mem_op_s) begin
          mem_stall       = rst;
          wb_rf_write_d_s = 1'b0;
        end else begin
          mem_stall       = 1'b0;
          wb_rf_write_d_s = ex_rf_write;
        end
      end
      BUSY: begin
        if (dm_ack) begin
          mem_stall       = 1'b0;
          wb_rf_write_d_s = dm_we ? 1'b0 : ex_rf_write;
          wb_data_d_s     = dm_rdata;
        end else if (timeout_s) begin
          mem_stall       = 1'b0;
          wb_rf_write_d_s = 1'b0;
        end else begin
          mem_stall       = rst;
          wb_rf_write_d_s = 1'b0;
        end
      end
      default: begin
        mem_stall       = 1'b0;
        wb_rf_write_d_s = 1'b0;
      end
    endcase
  end

  // Access FSM with registered memory interface, timeout counter and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= 16'd0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= {DW{1'b0}};
      dm_wdata <= {DW{1'b0}};
      mem_err  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= 16'd0;
          if (mem_op_s) begin
            dm_addr  <= ex_result;
            dm_wdata <= store_data_s;
            dm_we    <= ex_dm_write;
            dm_req   <= 1'b1;
            state_r  <= BUSY;
          end else begin
            dm_req   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        BUSY: begin
          if (dm_ack) begin
            dm_req  <= 1'b0;
            cnt_r   <= 16'd0;
            state_r <= IDLE;
          end else if (timeout_s) begin
            mem_err <= 1'b1;
            dm_req  <= 1'b0;
            cnt_r   <= 16'd0;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
            state_r <= BUSY;
          end
        end
        default: begin
          dm_req  <= 1'b0;
          cnt_r   <= 16'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  memwb_register #(.DW(DW), .RW(RW)) u_memwb (
    .clk         (clk),
    .rst         (rst),
    .rf_write_d  (wb_rf_write_d_s),
    .write_reg_d (wb_write_reg_d_s),
    .data_d      (wb_data_d_s),
    .rf_write_q  (wb_rf_write),
    .write_reg_q (wb_write_reg),
    .data_q      (wb_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (TIMEOUT_CYCLES=4). Write-backs are
// checked through a scoreboard queue; handshake timing is checked directly.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_rf_write = 1'b0, ex_dm_write = 1'b0, ex_memtoreg = 1'b0;
  logic [15:0] ex_result = 16'd0, ex_store_data = 16'd0;
  logic [3:0]  ex_read_reg2 = 4'd0, ex_write_reg = 4'd0;
  logic        dm_req, dm_we, dm_ack = 1'b0;
  logic [15:0] dm_addr, dm_wdata, dm_rdata = 16'd0;
  logic        mem_stall, mem_err, wb_rf_write;
  logic [3:0]  wb_write_reg;
  logic [15:0] wb_data;

  typedef struct {
    logic [3:0]  rg;
    logic [15:0] data;
  } wb_t;
  wb_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.DW(16), .RW(4), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_rf_write(ex_rf_write), .ex_dm_write(ex_dm_write), .ex_memtoreg(ex_memtoreg),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_read_reg2(ex_read_reg2), .ex_write_reg(ex_write_reg),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .mem_err(mem_err),
    .wb_rf_write(wb_rf_write), .wb_write_reg(wb_write_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic rf, input logic dmw, input logic m2r,
                        input logic [15:0] res, input logic [15:0] sd,
                        input logic [3:0] rr2, input logic [3:0] wr);
    ex_rf_write = rf; ex_dm_write = dmw; ex_memtoreg = m2r;
    ex_result = res; ex_store_data = sd; ex_read_reg2 = rr2; ex_write_reg = wr;
  endtask

  // Drive one memory access (inputs already set) to completion; ack_at=0 never acks.
  task automatic run_access(input int ack_at, input logic [15:0] exp_addr,
                            input logic exp_we, input logic [15:0] exp_wdata,
                            input logic [15:0] rdata,
                            output int stalls, output int reqs);
    int  busy = 0;
    bit  done = 0;
    stalls = 0; reqs = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (dm_req) begin
        busy++; reqs++;
        check("dm_addr", dm_addr, exp_addr);
        check("dm_we", dm_we, exp_we);
        if (exp_we) check("dm_wdata", dm_wdata, exp_wdata);
        if (busy == ack_at) begin dm_ack = 1'b1; dm_rdata = rdata; end
      end
      #1;
      if (mem_stall) stalls++;
      if (dm_req && !mem_stall) done = 1;
      step();
      dm_ack = 1'b0; dm_rdata = 16'd0;
    end
    if (!done) check("access_bound", 32'd0, 32'd1);
    set_ex(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 4'd0);
  endtask

  // Scoreboard: every observed write-back must match the oldest expected one.
  always @(negedge clk) begin
    if (rst && wb_rf_write) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        check("wb_reg", wb_write_reg, e.rg);
        check("wb_data", wb_data, e.data);
      end
    end
  end

  int st, rq;
  logic [15:0] fwd_exp;

  initial begin
    #12;
    check("rst_req", dm_req, 1'b0);
    check("rst_wb", {wb_rf_write, wb_write_reg, wb_data}, 32'd0);
    check("rst_err", mem_err, 1'b0);
    @(negedge clk); rst = 1'b1;
    step();

    // 1: ALU pass-through, 1-cycle latency, no stall
    set_ex(1'b1, 1'b0, 1'b0, 16'h1234, 16'd0, 4'd0, 4'd3);
    sb_q.push_back('{rg: 4'd3, data: 16'h1234});
    #1 check("t1_stall", mem_stall, 1'b0);
    step();
    check("t1_wbwr", wb_rf_write, 1'b1);
    check("t1_stall2", mem_stall, 1'b0);
    set_ex(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 4'd0);
    step();

    // 2: load, ack on the 3rd BUSY cycle
    set_ex(1'b1, 1'b0, 1'b1, 16'h0040, 16'd0, 4'd0, 4'd5);
    sb_q.push_back('{rg: 4'd5, data: 16'hBEEF});
    run_access(3, 16'h0040, 1'b0, 16'd0, 16'hBEEF, st, rq);
    check("t2_reqs", rq, 3);
    check("t2_stalls", st, 3);
    check("t2_wbwr", wb_rf_write, 1'b1);
    check("t2_req_low", dm_req, 1'b0);
    step();

    // 3: store, ack in first BUSY cycle, no write-back
    set_ex(1'b1, 1'b1, 1'b0, 16'h0010, 16'h00AA, 4'd0, 4'd6);
    run_access(1, 16'h0010, 1'b1, 16'h00AA, 16'd0, st, rq);
    check("t3_reqs", rq, 1);
    check("t3_stalls", st, 1);
    check("t3_wbwr", wb_rf_write, 1'b0);
    step();

    // 4: timeout after 4 BUSY cycles, sticky error, then ALU op still works
    set_ex(1'b1, 1'b0, 1'b1, 16'h0020, 16'd0, 4'd0, 4'd4);
    run_access(0, 16'h0020, 1'b0, 16'd0, 16'd0, st, rq);
    check("t4_reqs", rq, 4);
    check("t4_stalls", st, 4);
    check("t4_err", mem_err, 1'b1);
    check("t4_wbwr", wb_rf_write, 1'b0);
    check("t4_req_low", dm_req, 1'b0);
    set_ex(1'b1, 1'b0, 1'b0, 16'h7777, 16'd0, 4'd0, 4'd7);
    sb_q.push_back('{rg: 4'd7, data: 16'h7777});
    step();
    check("t4_alu_wbwr", wb_rf_write, 1'b1);
    check("t4_err_sticky", mem_err, 1'b1);
    set_ex(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 4'd0);
    step();

    // 5: asynchronous reset while BUSY, late ack ignored
    set_ex(1'b1, 1'b0, 1'b1, 16'h0080, 16'd0, 4'd0, 4'd9);
    step(); step();
    check("t5_busy", dm_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t5_req", dm_req, 1'b0);
    check("t5_stall", mem_stall, 1'b0);
    check("t5_wb", {wb_rf_write, wb_write_reg, wb_data}, 32'd0);
    check("t5_err", mem_err, 1'b0);
    set_ex(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 4'd0);
    step();
    rst = 1'b1;
    dm_ack = 1'b1; dm_rdata = 16'hDEAD;
    step();
    dm_ack = 1'b0; dm_rdata = 16'd0;
    check("t5_late_wb", wb_rf_write, 1'b0);
    check("t5_late_req", dm_req, 1'b0);
    step();
    check("t5_late_wb2", wb_rf_write, 1'b0);

    // 6: load r2 then immediately store r2's value
    set_ex(1'b1, 1'b0, 1'b1, 16'h0100, 16'd0, 4'd0, 4'd2);
    sb_q.push_back('{rg: 4'd2, data: 16'h5555});
    run_access(1, 16'h0100, 1'b0, 16'd0, 16'h5555, st, rq);
`ifdef MEM_FWD_EN
    fwd_exp = 16'h5555;
`else
    fwd_exp = 16'h0000;
`endif
    set_ex(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 4'd2, 4'd0);
    run_access(1, 16'h0200, 1'b1, fwd_exp, 16'd0, st, rq);
    check("t6_reqs", rq, 1);
    step(); step();

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
